// File: rtl/bep_encoder.sv
// Biphase-mark serial encoder: one byte per valid/ready handshake, framed as
// sync(1,1) + d0..d7 (LSB first) + even parity, followed by an idle gap.
module bep_encoder #(
   parameter int unsigned HALF_BIT_CYCLES = 4,
   parameter int unsigned GAP_BITS        = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       bep_out,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned HCW = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
   localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF_BIT_CYCLES - 1);
   localparam logic [3:0]     GAP_LAST  = 4'(GAP_BITS - 1);
   localparam logic [3:0]     SYNC_LAST = 4'd1;
   localparam logic [3:0]     DATA_LAST = 4'd9;
   localparam logic [3:0]     BIT_LAST  = 4'd10;

   typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} state_t;

   state_t           r_state, w_state;
   logic [HCW-1:0]   r_half_cnt, w_half_cnt;
   logic             r_phase, w_phase;
   logic [3:0]       r_bit_idx, w_bit_idx;
   logic [3:0]       r_gap_cnt, w_gap_cnt;
   logic [7:0]       r_shift, w_shift;
   logic             r_parity, w_parity;
   logic             r_bep, w_bep;
   logic             r_frame_done, w_frame_done;

   logic             w_wrap, w_mid, w_cell_end, w_cur_bit;

   assign w_wrap     = (r_half_cnt == HALF_LAST);
   assign w_mid      = w_wrap & ~r_phase;
   assign w_cell_end = w_wrap & r_phase;
   assign w_cur_bit  = (r_state == SYNC) ? 1'b1 :
                       (r_state == DATA) ? r_shift[0] : r_parity;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_half_cnt   <= '0;
         r_phase      <= 1'b0;
         r_bit_idx    <= '0;
         r_gap_cnt    <= '0;
         r_shift      <= '0;
         r_parity     <= 1'b0;
         r_bep        <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_half_cnt   <= w_half_cnt;
         r_phase      <= w_phase;
         r_bit_idx    <= w_bit_idx;
         r_gap_cnt    <= w_gap_cnt;
         r_shift      <= w_shift;
         r_parity     <= w_parity;
         r_bep        <= w_bep;
         r_frame_done <= w_frame_done;
      end
   end

   // Next-state and next-output logic; the half-bit timebase runs in every
   // state but IDLE, and each wrap alternates between mid-cell and cell end.
   always_comb begin
      w_state      = r_state;
      w_half_cnt   = r_half_cnt;
      w_phase      = r_phase;
      w_bit_idx    = r_bit_idx;
      w_gap_cnt    = r_gap_cnt;
      w_shift      = r_shift;
      w_parity     = r_parity;
      w_bep        = r_bep;
      w_frame_done = 1'b0;

      if (r_state != IDLE) begin
         w_half_cnt = w_wrap ? '0 : r_half_cnt + 1'b1;
         if (w_wrap) w_phase = ~r_phase;
      end

      case (r_state)
         IDLE: begin
            if (tx_valid) begin
               w_state    = SYNC;
               w_shift    = tx_data;
               w_parity   = ^tx_data;
               w_bep      = ~r_bep;
               w_half_cnt = '0;
               w_phase    = 1'b0;
               w_bit_idx  = '0;
            end
         end
         SYNC, DATA, PARITY: begin
            if (w_mid && w_cur_bit) w_bep = ~r_bep;
            if (w_cell_end) begin
               // Cell-start toggle of the next cell, or the closing toggle.
               w_bep = ~r_bep;
               if (r_state == DATA) w_shift = {1'b0, r_shift[7:1]};
               if (r_bit_idx == BIT_LAST) begin
                  w_state      = GAP;
                  w_bit_idx    = '0;
                  w_gap_cnt    = '0;
                  w_frame_done = 1'b1;
               end else begin
                  w_bit_idx = r_bit_idx + 4'd1;
                  if (r_bit_idx == SYNC_LAST) w_state = DATA;
                  if (r_bit_idx == DATA_LAST) w_state = PARITY;
               end
            end
         end
         GAP: begin
            if (w_cell_end) begin
               if (r_gap_cnt == GAP_LAST) begin
                  w_state   = IDLE;
                  w_gap_cnt = '0;
               end else begin
                  w_gap_cnt = r_gap_cnt + 4'd1;
               end
            end
         end
         default: w_state = IDLE;
      endcase
   end

   assign tx_ready   = (r_state == IDLE);
   assign busy       = (r_state != IDLE);
   assign bep_out    = r_bep;
   assign frame_done = r_frame_done;

endmodule
